// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection datapath.
package edge_pkg;

  localparam int unsigned BUF_COLS  = 4;
  localparam int unsigned BUF_ROWS  = 3;
  localparam int unsigned WIN1_COL0 = 0;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [BUF_ROWS*BUF_COLS-1:0] pix_buf_t;
  typedef logic signed [10:0] grad_t;

endpackage

// File: rtl/sobel_gx_kernel.sv
// Combinational horizontal Sobel kernel over one 3x3 window (pRC = row R, column C).
module sobel_gx_kernel
  import edge_pkg::*;
(
  input  pixel_t p00,
  input  pixel_t p01,
  input  pixel_t p02,
  input  pixel_t p10,
  input  pixel_t p11,
  input  pixel_t p12,
  input  pixel_t p20,
  input  pixel_t p21,
  input  pixel_t p22,
  output grad_t  gx
);

  localparam int unsigned SIDE_W = 10;

  logic [SIDE_W-1:0] pos_sum;
  logic [SIDE_W-1:0] neg_sum;
  logic              unused_mid;

  // Weighted column sums; each side peaks at 1020 so 10 bits never overflow.
  assign pos_sum = SIDE_W'(p02) + (SIDE_W'(p12) << 1) + SIDE_W'(p22);
  assign neg_sum = SIDE_W'(p00) + (SIDE_W'(p10) << 1) + SIDE_W'(p20);

  // Difference spans -1020..+1020, which fits an 11-bit signed result.
  assign gx = grad_t'({1'b0, pos_sum}) - grad_t'({1'b0, neg_sum});

  // Middle column carries zero weight.
  assign unused_mid = ^{p01, p11, p21};

endmodule

// File: rtl/gx_block_window_1.sv
// Gx for the leftmost 3x3 window of the 3x4 pixel buffer, loaded on enable_calc.
// Optional macro GX_ABS_OUTPUT_EN: output |Gx| instead of signed Gx.
module gx_block_window_1
  import edge_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  pix_buf_t    data_buffer,
  input  logic        enable_calc,
  output logic [10:0] gx_out_1
);

  localparam int unsigned R0 = 0;
  localparam int unsigned R1 = BUF_COLS;
  localparam int unsigned R2 = 2 * BUF_COLS;

  grad_t       gx;
  logic [10:0] gx_next;
  logic        unused_col3;

  sobel_gx_kernel u_kernel (
    .p00 (data_buffer[R0 + WIN1_COL0]),
    .p01 (data_buffer[R0 + WIN1_COL0 + 1]),
    .p02 (data_buffer[R0 + WIN1_COL0 + 2]),
    .p10 (data_buffer[R1 + WIN1_COL0]),
    .p11 (data_buffer[R1 + WIN1_COL0 + 1]),
    .p12 (data_buffer[R1 + WIN1_COL0 + 2]),
    .p20 (data_buffer[R2 + WIN1_COL0]),
    .p21 (data_buffer[R2 + WIN1_COL0 + 1]),
    .p22 (data_buffer[R2 + WIN1_COL0 + 2]),
    .gx  (gx)
  );

  // Column 3 belongs to the neighbouring window only.
  assign unused_col3 = ^{data_buffer[R0 + 3], data_buffer[R1 + 3], data_buffer[R2 + 3]};

`ifdef GX_ABS_OUTPUT_EN
  // Magnitude ahead of the register keeps latency at one cycle.
  assign gx_next = gx[10] ? 11'(-gx) : 11'(gx);
`else
  assign gx_next = 11'(gx);
`endif

  // Enable-gated result register with asynchronous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gx_out_1 <= 11'd0;
    end else if (enable_calc) begin
      gx_out_1 <= gx_next;
    end
  end

endmodule

// File: tb/tb_gx_block_window_1.sv
// Randomised and directed bench for gx_block_window_1 against an arithmetic model.
module tb_gx_block_window_1;
  import edge_pkg::*;

  logic        clk;
  logic        n_rst;
  pix_buf_t    data_buffer;
  logic        enable_calc;
  logic [10:0] gx_out_1;

  int unsigned vectors;
  int unsigned miscompares;
  logic [10:0] exp_q;
  pix_buf_t    d;

`ifdef GX_ABS_OUTPUT_EN
  localparam logic [10:0] NEG_EXTREME = 11'd1020;
`else
  localparam logic [10:0] NEG_EXTREME = 11'h404;
`endif

  gx_block_window_1 dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .data_buffer (data_buffer),
    .enable_calc (enable_calc),
    .gx_out_1    (gx_out_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: weighted right column minus weighted left column, rows weighted 1,2,1.
  function automatic logic [10:0] gx_ref(input pix_buf_t b);
    int acc;
    acc = 0;
    for (int r = 0; r < 3; r++) begin
      acc += ((r == 1) ? 2 : 1) * (int'(b[4*r+2]) - int'(b[4*r]));
    end
`ifdef GX_ABS_OUTPUT_EN
    if (acc < 0) acc = -acc;
`endif
    return 11'(acc);
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h)", tag, got, got, want, want);
    end
  endtask

  // Drive one cycle, update the model on an enabled edge, check 1 ns after it.
  task automatic apply(input pix_buf_t b, input logic en, input string tag);
    data_buffer = b;
    enable_calc = en;
    @(posedge clk);
    if (en) exp_q = gx_ref(b);
    #1;
    check(tag, gx_out_1, exp_q);
  endtask

  function automatic pix_buf_t fill(input int v);
    pix_buf_t b;
    for (int k = 0; k < 12; k++) b[k] = pixel_t'(v);
    return b;
  endfunction

  function automatic pix_buf_t rand_buf();
    pix_buf_t b;
    for (int k = 0; k < 12; k++) b[k] = pixel_t'($urandom_range(255));
    return b;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_q       = 11'd0;

    // Reset with enable high and live data.
    n_rst       = 1'b0;
    enable_calc = 1'b1;
    data_buffer = rand_buf();
    #3;
    check("reset_init", gx_out_1, 11'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", gx_out_1, 11'd0);
    @(negedge clk);
    n_rst = 1'b1;
    enable_calc = 1'b0;
    #1;
    check("reset_release", gx_out_1, 11'd0);

    // Step edge: indices 0..5 = 100, 6..11 = 200.
    for (int k = 0; k < 12; k++) d[k] = (k < 6) ? 8'd100 : 8'd200;
    apply(d, 1'b1, "step_model");
    check("step_200", gx_out_1, 11'd200);

    // Uniform field.
    apply(fill(50), 1'b1, "uniform_model");
    check("uniform_0", gx_out_1, 11'd0);

    // Negative extreme: column 0 = 255, others 0.
    d = fill(0);
    for (int r = 0; r < 3; r++) d[4*r] = 8'd255;
    apply(d, 1'b1, "neg_model");
    check("neg_extreme", gx_out_1, NEG_EXTREME);

    // Positive extreme with random column 3, then perturb columns 3 and 1.
    d = fill(0);
    for (int r = 0; r < 3; r++) begin
      d[4*r+2] = 8'd255;
      d[4*r+3] = pixel_t'($urandom_range(255));
    end
    apply(d, 1'b1, "pos_model");
    check("pos_extreme", gx_out_1, 11'd1020);
    for (int r = 0; r < 3; r++) d[4*r+3] = pixel_t'($urandom_range(255));
    apply(d, 1'b1, "col3_change");
    check("col3_isolated", gx_out_1, 11'd1020);
    for (int r = 0; r < 3; r++) d[4*r+1] = pixel_t'($urandom_range(1, 255));
    apply(d, 1'b1, "col1_change");
    check("col1_isolated", gx_out_1, 11'd1020);

    // Hold: load 200, then all-zero data with enable low for 5 cycles.
    for (int k = 0; k < 12; k++) d[k] = (k < 6) ? 8'd100 : 8'd200;
    apply(d, 1'b1, "hold_load");
    for (int i = 0; i < 5; i++) begin
      apply(fill(0), 1'b0, "hold_model");
      check("hold_200", gx_out_1, 11'd200);
    end
    apply(fill(0), 1'b1, "reenable_model");
    check("reenable_0", gx_out_1, 11'd0);

    // Mid-operation reset clears asynchronously.
    apply(d, 1'b1, "pre_reset_load");
    #3;
    n_rst = 1'b0;
    #1;
    check("reset_mid", gx_out_1, 11'd0);
    exp_q = 11'd0;
    @(negedge clk);
    n_rst = 1'b1;
    apply(d, 1'b0, "post_reset_idle");
    apply(d, 1'b1, "post_reset_load");
    check("post_reset_200", gx_out_1, 11'd200);

    // Random enables and pixels, including back-to-back loads.
    for (int i = 0; i < 400; i++) begin
      apply(rand_buf(), 1'($urandom_range(3) != 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
